matrix_transpose: RTL and testbench



---
 rtl/matrix_transpose_pkg.sv | 11 +
 rtl/matrix_transpose_core.sv | 22 ++
 rtl/matrix_transpose.sv | 48 ++++
 tb/tb_matrix_transpose.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/matrix_transpose_pkg.sv
// Shared element-indexing helper for the matrix transposer and anything that
// needs to address elements inside a row-major flattened matrix bus.
package matrix_transpose_pkg;

  // Bit offset of element (row, col) in a row-major matrix with ncols columns.
  function automatic int elem_lsb(input int row, input int col,
                                  input int ncols, input int width);
    return ((row * ncols) + col) * width;
  endfunction

endpackage

// File: rtl/matrix_transpose_core.sv
// Purely combinational M x N -> N x M transpose on flat row-major buses.
module matrix_transpose_core
  import matrix_transpose_pkg::*;
#(
  parameter int M          = 6,
  parameter int N          = 6,
  parameter int DATA_WIDTH = 8
) (
  input  logic [M*N*DATA_WIDTH-1:0] a,
  output logic [M*N*DATA_WIDTH-1:0] b
);

  // Pure wiring: output (row j, col i) is input (row i, col j).
  for (genvar i = 0; i < M; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      localparam int A_LSB = elem_lsb(i, j, N, DATA_WIDTH);
      localparam int B_LSB = elem_lsb(j, i, M, DATA_WIDTH);
      assign b[B_LSB +: DATA_WIDTH] = a[A_LSB +: DATA_WIDTH];
    end
  end

endmodule

// File: rtl/matrix_transpose.sv
// Registered matrix transposer: one output register stage with valid/ready,
// full throughput of one matrix per cycle.
module matrix_transpose
  import matrix_transpose_pkg::*;
#(
  parameter int M          = 6,
  parameter int N          = 6,
  parameter int DATA_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [M*N*DATA_WIDTH-1:0] a,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [M*N*DATA_WIDTH-1:0] b
);

  logic [M*N*DATA_WIDTH-1:0] bt;
  logic                      accept;

  matrix_transpose_core #(
    .M          (M),
    .N          (N),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_core (
    .a (a),
    .b (bt)
  );

  // The slot frees up whenever its current contents leave this same cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      b         <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      b         <= bt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_matrix_transpose.sv
// Randomized + directed bench for matrix_transpose against a queue-based
// transpose model and a one-slot handshake model.
module tb_matrix_transpose;

  localparam int M  = 6;
  localparam int N  = 6;
  localparam int W  = 8;
  localparam int TW = M*N*W;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, out_ready;
  logic [TW-1:0] a;
  logic          in_ready, out_valid;
  logic [TW-1:0] b;

  logic          ns_in_valid, ns_out_ready;
  logic [47:0]   ns_a;
  logic          ns_in_ready, ns_out_valid;
  logic [47:0]   ns_b;

  int n_cmp = 0;
  int n_err = 0;

  // Reference slot state
  bit            mv;
  logic [TW-1:0] mb;

  always #5 clk = ~clk;

  matrix_transpose #(.M(M), .N(N), .DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a),
    .out_valid(out_valid), .out_ready(out_ready), .b(b)
  );

  matrix_transpose #(.M(2), .N(3), .DATA_WIDTH(8)) dut_ns (
    .clk(clk), .rst(rst), .in_valid(ns_in_valid), .in_ready(ns_in_ready), .a(ns_a),
    .out_valid(ns_out_valid), .out_ready(ns_out_ready), .b(ns_b)
  );

  task automatic chk(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Read elements out in row-major order into a grid, then emit them column by column.
  function automatic logic [TW-1:0] ref_t(input logic [TW-1:0] x);
    logic [W-1:0] grid [M][N];
    logic [W-1:0] q [$];
    logic [TW-1:0] r;
    logic [TW-1:0] s;
    s = x;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++) begin
        grid[i][j] = s[W-1:0];
        s = s >> W;
      end
    for (int rr = 0; rr < N; rr++)
      for (int cc = 0; cc < M; cc++)
        q.push_back(grid[cc][rr]);
    r = '0;
    while (q.size() > 0) r = (r << W) | TW'(q.pop_back());
    return r;
  endfunction

  function automatic logic [TW-1:0] rnd_mat();
    logic [TW-1:0] x;
    for (int k = 0; k < TW/32; k++) x[k*32 +: 32] = $urandom;
    return x;
  endfunction

  // One clock: drive, check ready, clock, update model, check outputs.
  task automatic cycle(input logic iv, input logic orr, input logic [TW-1:0] av, input logic r);
    bit acc;
    in_valid = iv; out_ready = orr; a = av; rst = r;
    #1;
    if (!r) chk("in_ready", TW'(in_ready), TW'(!mv || orr));
    acc = iv && (!mv || orr);
    @(posedge clk);
    if (r) begin mv = 0; mb = '0; end
    else if (acc) begin mv = 1; mb = ref_t(av); end
    else if (mv && orr) mv = 0;
    #1;
    chk("out_valid", TW'(out_valid), TW'(mv));
    chk("b", b, mb);
  endtask

  initial begin
    logic [TW-1:0] x, y, xt, p;
    int got_cnt;
    mv = 0; mb = '0;
    ns_in_valid = 0; ns_out_ready = 1; ns_a = '0;
    in_valid = 0; out_ready = 0; a = '0; rst = 1;
    @(posedge clk); #1;

    // Reset held for 2 cycles with in_valid asserted
    cycle(1, 1, rnd_mat(), 1);
    cycle(1, 1, rnd_mat(), 1);
    chk("rst_out_valid", TW'(out_valid), '0);
    chk("rst_b", b, '0);
    rst = 0; in_valid = 0; #1;
    chk("rst_in_ready", TW'(in_ready), TW'(1));

    // Low bytes cc,ee,ee,aa across row 0
    x = rnd_mat();
    x[31:0] = 32'haaeeeecc;
    cycle(1, 1, x, 0);
    chk("dir_b0", TW'(b[7:0]), TW'(8'hcc));
    chk("dir_b6", TW'(b[55:48]), TW'(8'hee));
    chk("dir_b12", TW'(b[103:96]), TW'(8'hee));
    chk("dir_b18", TW'(b[151:144]), TW'(8'haa));

    // Index pattern: element (i,j) = i*16+j
    p = '0;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++)
        p[(i*N+j)*W +: W] = W'(i*16 + j);
    cycle(1, 1, p, 0);
    chk("idx_b1", TW'(b[15:8]), TW'(8'h10));
    chk("idx_b35", TW'(b[287:280]), TW'(8'h55));
    for (int r = 0; r < N; r++)
      for (int c = 0; c < M; c++)
        chk("idx_elem", TW'(b[(r*M+c)*W +: W]), TW'(c*16 + r));
    cycle(0, 1, '0, 0);

    // Non-square 2x3 instance
    ns_a = 48'h060504030201; ns_in_valid = 1; ns_out_ready = 1;
    @(posedge clk); #1;
    ns_in_valid = 0;
    chk("ns_valid", TW'(ns_out_valid), TW'(1));
    chk("ns_b", TW'(ns_b), TW'(48'h060305020401));
    @(posedge clk); #1;
    chk("ns_drain", TW'(ns_out_valid), TW'(0));

    // Backpressure: X held while Y waits
    x = rnd_mat(); y = rnd_mat(); xt = ref_t(x);
    cycle(1, 1, x, 0);
    for (int k = 0; k < 3; k++) begin
      cycle(1, 0, y, 0);
      chk("bp_in_ready", TW'(in_ready), '0);
      chk("bp_hold", b, xt);
    end
    cycle(1, 1, y, 0);
    chk("bp_next", b, ref_t(y));
    cycle(0, 1, rnd_mat(), 0);
    chk("bp_drained", TW'(out_valid), '0);

    // Streaming 4 matrices back to back
    got_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      x = rnd_mat();
      cycle(1, 1, x, 0);
      if (out_valid && b === ref_t(x)) got_cnt++;
    end
    chk("stream_cnt", TW'(got_cnt), TW'(4));
    cycle(0, 1, '0, 0);

    // Reset during a stall discards the held matrix
    cycle(1, 0, rnd_mat(), 0);
    cycle(1, 0, rnd_mat(), 0);
    cycle(1, 0, rnd_mat(), 1);
    chk("stall_rst_valid", TW'(out_valid), '0);
    chk("stall_rst_b", b, '0);

    // Random traffic
    for (int k = 0; k < 300; k++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd_mat(),
            1'($urandom_range(0, 49) == 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
